seq_div: RTL and testbench
==========================

Name: seq_div

Overview:
- Sequential signed divider: the inverse operation of the team's 8-bit signed multiplier.
- Takes a 16-bit signed dividend and an 8-bit signed divisor. Returns a 16-bit signed quotient and an 8-bit signed remainder, using truncating (round-toward-zero) semantics.
- Radix-2 restoring, one quotient bit per clock, start/done handshake.
- Sits beside the multiplier in the arithmetic datapath. It recovers an operand from a product, or does general scaling.

Parameters:
- DW, 16, dividend and quotient width.
- VW, 8, divisor and remainder width (VW <= DW).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request. Sampled only in IDLE.
- dividend  input  DW  signed dividend, sampled with start.
- divisor  input  VW  signed divisor, sampled with start.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse: results valid.
- quotient  output  DW  signed quotient, held until next accepted start.
- remainder  output  VW  signed remainder, held until next accepted start.
- dz  output  1  divide-by-zero flag, valid with done, held with results.

Behaviour:
- Reset: rst=1 at an edge forces state IDLE and all outputs to 0 (busy, done, quotient, remainder, dz). rst wins over every other input and over an operation in flight.
- States: IDLE, CALC, FIX.
- IDLE -> CALC on edge with start=1. That edge:
  - latches |dividend| and |divisor| (two's-complement negate when MSB=1);
  - latches sign_q = dividend[DW-1]^divisor[VW-1] and sign_r = dividend[DW-1];
  - latches dz = (divisor==0);
  - clears the partial remainder (VW+1 bits) and the iteration counter;
  - sets busy=1.
- CALC, one step per edge, DW edges total:
  - shift {rem, dvd} left by 1;
  - trial = rem - |divisor|; if trial >= 0, rem = trial and quotient bit = 1, else restore and bit = 0;
  - on the DW-th step go to FIX.
- FIX, one edge:
  - quotient = sign_q ? -|q| : |q| (DW-bit wrap);
  - remainder = sign_r ? -|r| : |r|;
  - if dz, quotient = 0 and remainder = 0;
  - busy=0, done=1, go to IDLE.
- Latency: done is high in the cycle after edge DW+1, counted from the start-sampling edge as edge 0. That is 17 edges for DW=16. Fixed and operand-independent, including dz.
- done is high for exactly one cycle.
- start while busy=1 is ignored; operands are not re-sampled.
- start=1 in the same cycle done=1 is accepted (state is IDLE). done drops and busy rises on that edge.
- Remainder magnitude < |divisor| <= 2^(VW-1), so it always fits VW signed bits.
- Sole quotient overflow: dividend = -2^(DW-1), divisor = -1. The quotient wraps to 0x8000 and the remainder is 0.
- quotient and remainder change only at the FIX edge or on reset.

Optional Feature:
- Macro SEQ_DIV_OVF_EN.
- Defined:
  - adds output port ovf (1 bit), cleared on reset;
  - set at the FIX edge iff dividend = -2^(DW-1) and divisor = -1, otherwise cleared there;
  - held with the results.
- Undefined: no ovf port and no overflow detection logic. The wrapped result is the same in both builds.

Decomposition:
- Package seq_div_pkg: state enum (IDLE, CALC, FIX), default DW/VW localparams, counter width $clog2(DW+1).
- One sub-module is natural: sign_mag_conv, a parameterised conditional two's-complement negate (in: value, neg; out: value or -value).
  - Instantiated for operand abs on load and for sign restore in FIX.

Test Plan:
- start with 100 / 7 -> quotient 14, remainder 2, dz 0; done exactly 17 edges after start edge, busy high 17 cycles.
- -100 / 7 -> quotient 0xFFF2 (-14), remainder 0xFE (-2); 100 / -7 -> quotient 0xFFF2, remainder 0x02.
- -32768 / -128 -> quotient 256, remainder 0. -32768 / -1 -> quotient 0x8000, remainder 0, ovf=1 (SEQ_DIV_OVF_EN build).
- 1234 / 0 -> dz=1, quotient 0, remainder 0, done at edge 17. The next op 1234 / 10 -> dz=0, quotient 123, remainder 4.
- start pulsed again at cycle 5 with different operands -> ignored, first result unchanged. Start asserted in the done cycle -> new op accepted back-to-back.
- rst=1 at cycle 8 of an op -> next cycle busy=0, done=0, outputs 0, and done never pulses for the aborted op. A fresh start then completes normally.

Source files
------------

// File: rtl/seq_div_pkg.sv
// rtl/seq_div_pkg.sv - shared types and defaults for the seq_div signed divider
package seq_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  localparam int DW_DEF = 16;
  localparam int VW_DEF = 8;
  localparam int CNT_W_DEF = $clog2(DW_DEF + 1);

endpackage

// File: rtl/seq_div_sign_mag_conv.sv
// rtl/seq_div_sign_mag_conv.sv - conditional two's-complement negate
module sign_mag_conv #(
  parameter int W = 8
) (
  input  logic [W-1:0] i_value,
  input  logic         i_neg,
  output logic [W-1:0] o_value
);

  assign o_value = i_neg ? (~i_value + W'(1)) : i_value;

endmodule

// File: rtl/seq_div.sv
// rtl/seq_div.sv - radix-2 restoring signed divider, one quotient bit per clock
// Optional macro SEQ_DIV_OVF_EN adds the ovf output for the -2^(DW-1) / -1 case.
module seq_div
  import seq_div_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int VW = VW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          dz
`ifdef SEQ_DIV_OVF_EN
  ,
  output logic          ovf
`endif
);

  localparam int CW = $clog2(DW + 1);

  state_t        r_state;
  logic [DW-1:0] r_dvd;
  logic [VW-1:0] r_dsr;
  logic [VW:0]   r_rem;
  logic [CW-1:0] r_cnt;
  logic          r_sign_q;
  logic          r_sign_r;
  logic          r_dz_pend;
  logic          r_busy;
  logic          r_done;
  logic [DW-1:0] r_quot;
  logic [VW-1:0] r_remo;
  logic          r_dz;

  logic [DW-1:0] w_dvd_abs;
  logic [VW-1:0] w_dsr_abs;
  logic [DW-1:0] w_q_signed;
  logic [VW-1:0] w_r_signed;
  logic [VW+1:0] w_sh;
  logic [VW:0]   w_trial;
  logic          w_ge;

  sign_mag_conv #(.W(DW)) u_abs_dvd (
    .i_value (dividend),
    .i_neg   (dividend[DW-1]),
    .o_value (w_dvd_abs)
  );

  sign_mag_conv #(.W(VW)) u_abs_dsr (
    .i_value (divisor),
    .i_neg   (divisor[VW-1]),
    .o_value (w_dsr_abs)
  );

  sign_mag_conv #(.W(DW)) u_fix_q (
    .i_value (r_dvd),
    .i_neg   (r_sign_q),
    .o_value (w_q_signed)
  );

  // The remainder magnitude is below |divisor|, so its low VW bits are exact.
  sign_mag_conv #(.W(VW)) u_fix_r (
    .i_value (r_rem[VW-1:0]),
    .i_neg   (r_sign_r),
    .o_value (w_r_signed)
  );

  assign w_sh    = {r_rem, r_dvd[DW-1]};
  assign w_ge    = (w_sh >= {2'b00, r_dsr});
  assign w_trial = w_sh[VW:0] - {1'b0, r_dsr};

`ifdef SEQ_DIV_OVF_EN
  logic r_ovf_pend;
  logic r_ovf;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf_pend <= 1'b0;
      r_ovf      <= 1'b0;
    end else if (r_state == IDLE && start) begin
      r_ovf_pend <= (dividend == {1'b1, {(DW-1){1'b0}}}) && (divisor == '1);
    end else if (r_state == FIX) begin
      r_ovf <= r_ovf_pend;
    end
  end

  assign ovf = r_ovf;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_dvd     <= '0;
      r_dsr     <= '0;
      r_rem     <= '0;
      r_cnt     <= '0;
      r_sign_q  <= 1'b0;
      r_sign_r  <= 1'b0;
      r_dz_pend <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_quot    <= '0;
      r_remo    <= '0;
      r_dz      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_dvd     <= w_dvd_abs;
            r_dsr     <= w_dsr_abs;
            r_sign_q  <= dividend[DW-1] ^ divisor[VW-1];
            r_sign_r  <= dividend[DW-1];
            r_dz_pend <= (divisor == '0);
            r_rem     <= '0;
            r_cnt     <= '0;
            r_busy    <= 1'b1;
            r_state   <= CALC;
          end
        end
        CALC: begin
          // r_dvd shifts out dividend bits and shifts in quotient bits.
          r_rem <= w_ge ? w_trial : w_sh[VW:0];
          r_dvd <= {r_dvd[DW-2:0], w_ge};
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == CW'(DW - 1)) begin
            r_state <= FIX;
          end
        end
        FIX: begin
          r_quot  <= r_dz_pend ? '0 : w_q_signed;
          r_remo  <= r_dz_pend ? '0 : w_r_signed;
          r_dz    <= r_dz_pend;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign quotient  = r_quot;
  assign remainder = r_remo;
  assign dz        = r_dz;

endmodule

// File: tb/tb_seq_div.sv
// tb/tb_seq_div.sv - randomized self-checking bench for seq_div against an arithmetic model
module tb_seq_div;

  logic               clk;
  logic               rst;
  logic               start;
  logic signed [15:0] dividend;
  logic signed [7:0]  divisor;
  logic               busy;
  logic               done;
  logic [15:0]        quotient;
  logic [7:0]         remainder;
  logic               dz;
`ifdef SEQ_DIV_OVF_EN
  logic               ovf;
`endif

  int n_vec;
  int n_err;

  seq_div dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .dz        (dz)
`ifdef SEQ_DIV_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer division truncates toward zero, as required.
  function automatic logic [15:0] model_q(input int a, input int b);
    if (b == 0) return 16'h0000;
    return 16'(a / b);
  endfunction

  function automatic logic [7:0] model_r(input int a, input int b);
    if (b == 0) return 8'h00;
    return 8'(a % b);
  endfunction

  // Called at a negedge; returns at the negedge after the start-sampling edge.
  task automatic launch(input logic signed [15:0] a, input logic signed [7:0] b);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    dividend = 16'($urandom);
    divisor  = 8'($urandom);
  endtask

  // Waits for done, checks latency, busy width and results; returns in the done cycle.
  task automatic finish_op(input logic signed [15:0] a, input logic signed [7:0] b, input bit poke);
    int cyc;
    int busy_cyc;
    int ai;
    int bi;
    ai = a;
    bi = b;
    cyc = 0;
    busy_cyc = 0;
    while (!done && cyc < 40) begin
      if (busy) busy_cyc++;
      start = poke && (cyc == 5);
      if (poke && cyc == 5) begin
        dividend = 16'sh1111;
        divisor  = 8'sh03;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check("latency", cyc, 17);
    check("busy_cycles", busy_cyc, 17);
    check("quotient", quotient, model_q(ai, bi));
    check("remainder", remainder, model_r(ai, bi));
    check("dz", dz, (bi == 0));
`ifdef SEQ_DIV_OVF_EN
    check("ovf", ovf, (ai == -32768 && bi == -1));
`endif
  endtask

  task automatic run_op(input logic signed [15:0] a, input logic signed [7:0] b);
    logic [15:0] q;
    launch(a, b);
    finish_op(a, b, 1'b0);
    q = quotient;
    @(negedge clk);
    check("done_pulse", done, 0);
    check("q_held", quotient, q);
  endtask

  logic signed [15:0] dir_a [12] = '{16'sd100, -16'sd100, 16'sd100, -16'sd32768, -16'sd32768,
                                     16'sd1234, 16'sd1234, -16'sd32768, 16'sd32767, -16'sd1,
                                     16'sd0, 16'sd7};
  logic signed [7:0]  dir_b [12] = '{8'sd7, 8'sd7, -8'sd7, -8'sd128, -8'sd1,
                                     8'sd0, 8'sd10, 8'sd1, -8'sd128, 8'sd127,
                                     -8'sd5, -8'sd128};

  initial begin
    int dn;
    logic signed [15:0] ra;
    logic signed [7:0]  rb;
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    start = 1'b0;
    dividend = '0;
    divisor = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_q", quotient, 0);
    check("rst_r", remainder, 0);
    check("rst_dz", dz, 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 12; i++) run_op(dir_a[i], dir_b[i]);

    // A second start mid-operation must be ignored.
    launch(16'sd100, 8'sd7);
    finish_op(16'sd100, 8'sd7, 1'b1);
    @(negedge clk);
    check("poke_idle", busy, 0);

    // Back-to-back: new start in the done cycle.
    launch(-16'sd5000, 8'sd33);
    finish_op(-16'sd5000, 8'sd33, 1'b0);
    launch(16'sd321, -8'sd9);
    check("b2b_busy", busy, 1);
    check("b2b_done", done, 0);
    finish_op(16'sd321, -8'sd9, 1'b0);
    @(negedge clk);

    // Reset in the middle of an operation aborts it.
    launch(16'sd500, 8'sd3);
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_q", quotient, 0);
    check("abort_r", remainder, 0);
    check("abort_dz", dz, 0);
    dn = 0;
    repeat (30) begin
      if (done) dn++;
      @(negedge clk);
    end
    check("abort_no_done", dn, 0);
    run_op(16'sd500, 8'sd3);

    for (int i = 0; i < 40; i++) begin
      ra = ($urandom_range(0, 7) == 0) ? -16'sd32768 : 16'($urandom);
      case ($urandom_range(0, 7))
        0: rb = 8'sd0;
        1: rb = -8'sd1;
        2: rb = -8'sd128;
        default: rb = 8'($urandom);
      endcase
      run_op(ra, rb);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
